// File: rtl/gpu_pkg.sv
// Shared types and constants for the GPU core scheduler slice.
package gpu_pkg;

    localparam int INSTR_W = 32;

    // An all-zero instruction word marks the end of a program.
    localparam logic [INSTR_W-1:0] END_OF_PROGRAM = '0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXECUTE,
        WRITEBACK,
        DONE
    } state_t;

endpackage

// File: rtl/gpu_thread_counter.sv
// Walks thread_id through 0..count-1 and flags the last thread of an instruction.
module gpu_thread_counter #(
    parameter int TID_W = 2,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] thread_count,
    output logic [TID_W-1:0] thread_id,
    output logic             last
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            thread_id <= '0;
        end else if (clear) begin
            thread_id <= '0;
        end else if (advance) begin
            thread_id <= thread_id + TID_W'(1);
        end
    end

    assign last = (CNT_W'(thread_id) + CNT_W'(1)) == thread_count;

endmodule

// File: rtl/gpu_core_scheduler.sv
// Launch scheduler: fetches each instruction once and replays it across all
// threads of the launch (execute then writeback per thread) until end-of-program.
module gpu_core_scheduler
    import gpu_pkg::*;
#(
    parameter  int NUM_THREADS = 4,
    parameter  int PC_W        = 8,
    localparam int TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    localparam int CNT_W       = $clog2(NUM_THREADS) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_W-1:0]    base_pc,
    input  logic [CNT_W-1:0]   thread_count,
    input  logic               abort,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [TID_W-1:0]   thread_id,
    output logic               exec_valid,
    output logic               we,
    output logic               busy,
    output logic               done,
    output logic               error
);

    state_t             state, state_nxt;
    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic [CNT_W-1:0]   tcount_q;
    logic               error_q;

    logic pc_load, pc_inc, instr_load, tc_load, err_set, err_clr;
    logic thread_clear, thread_adv, last_thread;
    logic count_ok;

    assign count_ok = (thread_count != '0) && (thread_count <= CNT_W'(NUM_THREADS));

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        pc_load      = 1'b0;
        pc_inc       = 1'b0;
        instr_load   = 1'b0;
        tc_load      = 1'b0;
        err_set      = 1'b0;
        err_clr      = 1'b0;
        thread_clear = 1'b0;
        thread_adv   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (count_ok) begin
                        pc_load      = 1'b1;
                        tc_load      = 1'b1;
                        err_clr      = 1'b1;
                        thread_clear = 1'b1;
                        state_nxt    = FETCH;
                    end else begin
                        err_set   = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            FETCH: begin
                if (abort) begin
                    state_nxt = DONE;
                end else if (imem_valid) begin
                    instr_load = 1'b1;
                    if (imem_rdata == END_OF_PROGRAM) begin
                        state_nxt = DONE;
                    end else begin
                        thread_clear = 1'b1;
                        state_nxt    = EXECUTE;
                    end
                end
            end
            EXECUTE: state_nxt = abort ? DONE : WRITEBACK;
            WRITEBACK: begin
                if (abort) begin
                    state_nxt = DONE;
                end else if (!last_thread) begin
                    thread_adv = 1'b1;
                    state_nxt  = EXECUTE;
                end else if (pc_q == '1) begin
                    // The program ran off the top of instruction memory.
                    err_set   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    pc_inc    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            tcount_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pc_load) begin
                pc_q <= base_pc;
            end else if (pc_inc) begin
                pc_q <= pc_q + PC_W'(1);
            end
            if (instr_load) instr_q  <= imem_rdata;
            if (tc_load)    tcount_q <= thread_count;
            if (err_set) begin
                error_q <= 1'b1;
            end else if (err_clr) begin
                error_q <= 1'b0;
            end
        end
    end

    gpu_thread_counter #(
        .TID_W(TID_W),
        .CNT_W(CNT_W)
    ) u_thread_counter (
        .clk         (clk),
        .reset       (reset),
        .clear       (thread_clear),
        .advance     (thread_adv),
        .thread_count(tcount_q),
        .thread_id   (thread_id),
        .last        (last_thread)
    );

    // Outputs decode straight from the state register, so reset clears them at once.
    assign imem_req   = (state == FETCH);
    assign imem_addr  = (state == FETCH) ? pc_q : '0;
    assign instr      = instr_q;
    assign exec_valid = (state == EXECUTE);
    assign we         = (state == WRITEBACK) && !abort;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign error      = error_q;

endmodule
